instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction fetch unit for the single-cycle/pipelined RISC-V core; it is the requester side of the instruction ROM. It holds the program counter and drives the ROM word address. It captures the combinational ROM word into an IF/ID output register and advances the PC. It also applies stall and redirect (branch/jump) requests from downstream and stops on end-of-program or address faults.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.
- ADDR_BITS, 5, ROM word-address width; the valid program range is 0 .. 4*2^ADDR_BITS-1 bytes.

Ports:
- clk  in  1  system clock, rising-edge active.
- reset  in  1  asynchronous, active-high reset; one clock domain.
- stall  in  1  hold PC and IF/ID outputs this cycle.
- redirect_valid  in  1  load redirect_pc into the PC and flush the IF/ID register.
- redirect_pc  in  32  branch/jump target byte address.
- rom_addr  out  ADDR_BITS  word address to the ROM, equal to pc[ADDR_BITS+1:2] (combinational from the PC register).
- rom_data  in  32  instruction word returned combinationally by the ROM.
- if_valid  out  1  if_inst/if_pc hold a real instruction.
- if_inst  out  32  fetched instruction.
- if_pc  out  32  byte address of if_inst.
- halted  out  1  unit is in HALT.
- fault  out  1  unit is in FAULT (misaligned or out-of-range PC).

## Operation
- State machine RUN / HALT / FAULT.
  - Reset enters RUN.
  - HALT and FAULT are sticky until reset.
- Internal pc register is 32 bits. A fetch is in range iff pc[31:ADDR_BITS+2] == 0.
- RUN, evaluated each rising edge in priority order:
  1. redirect_valid:
     - If redirect_pc[1:0] != 0: go to FAULT and clear if_valid.
     - Otherwise: pc <= redirect_pc and if_valid <= 0 (flush); if_inst/if_pc hold.
  2. stall: pc, if_valid, if_inst and if_pc all hold.
  3. pc out of range: go to FAULT and clear if_valid.
  4. Normal fetch: if_inst <= rom_data, if_pc <= pc, if_valid <= 1, pc <= pc + 4.
- PC increment wraps modulo 2^32. In practice the out-of-range check fires first.
- HALT/FAULT:
  - pc and if_inst/if_pc frozen; if_valid = 0.
  - stall and redirect are ignored.
- halted = (state == HALT); fault = (state == FAULT). Both are registered state decodes.

## Timing
- Reset values (asynchronous):
  - pc = RESET_PC, state = RUN.
  - if_valid = 0, if_inst = 32'h0000_0000, if_pc = 32'h0000_0000.
  - halted = 0, fault = 0.
- Latency: the instruction at address A appears on if_inst one clock edge after pc == A with no stall. Throughput is 1 instruction/cycle.
- Redirect penalty is one bubble. The edge that accepts the redirect outputs if_valid = 0. The target instruction is valid after the next edge.
- Redirect and stall asserted together: the redirect wins.
- Reset asserted mid-operation: all state returns to reset values immediately, without waiting for a clock edge.
- rom_addr changes only after a pc update; there is no combinational path from the stall/redirect inputs to rom_addr.

## Configuration
- IFETCH_ZERO_HALT_EN:
  - Defined: a normal fetch whose rom_data == 32'h0000_0000 sets state <= HALT and if_valid <= 0. pc is not advanced, and the zero word is never presented as valid. Redirect and stall in the same cycle take priority per the Operation order.
  - Undefined: zero words are fetched and presented as ordinary instructions. HALT is unreachable and halted stays 0.

## Test plan
- Reset, run 4 cycles with the ROM holding the 30-word test program:
  - Edges 1–4 present if_pc 0, 4, 8, 12 with if_inst 00300413, 00100493, 01000913, 009462b3.
  - if_valid = 1 from edge 1.
- stall high for 3 cycles with pc = 0x14:
  - if_inst/if_pc and rom_addr hold.
  - Release: the next edge presents if_pc = 0x14, if_inst = 009403b3.
- redirect_valid with redirect_pc = 0x34 and stall asserted together:
  - Next edge if_valid = 0.
  - Following edge if_pc = 0x34, if_inst = 01228863.
- redirect_pc = 0x36:
  - FAULT: fault = 1, if_valid = 0.
  - A later redirect to 0x0 is ignored; only reset clears the fault.
- Run sequentially to pc = 0x80 with ADDR_BITS = 5 (word 31 made nonzero for this test): fault = 1 after the edge at pc = 0x80, no word presented.
- With IFETCH_ZERO_HALT_EN, run to word 30 (0x78): halted = 1, if_valid = 0, pc stays 0x78. Without the macro: if_inst = 0 is presented valid at if_pc = 0x78.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction fetch unit: holds the PC, drives the ROM word address and
// registers fetched words into IF/ID. Optional zero-word halt: IFETCH_ZERO_HALT_EN.
module instr_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          ADDR_BITS = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stall,
    input  logic                 redirect_valid,
    input  logic [31:0]          redirect_pc,
    output logic [ADDR_BITS-1:0] rom_addr,
    input  logic [31:0]          rom_data,
    output logic                 if_valid,
    output logic [31:0]          if_inst,
    output logic [31:0]          if_pc,
    output logic                 halted,
    output logic                 fault
);

    // state | meaning
    // RUN   | fetching, honours redirect/stall
    // HALT  | zero word reached; frozen until reset
    // FAULT | misaligned redirect or PC outside ROM; frozen until reset
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        HALT  = 2'd1,
        FAULT = 2'd2
    } state_t;

    state_t      state, state_n;
    logic [31:0] pc, pc_n;
    logic        valid_n;
    logic [31:0] inst_n, ipc_n;
    logic        pc_bad;
    logic        zero_word;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= RUN;
            pc       <= RESET_PC;
            if_valid <= 1'b0;
            if_inst  <= 32'h0000_0000;
            if_pc    <= 32'h0000_0000;
        end else begin
            state    <= state_n;
            pc       <= pc_n;
            if_valid <= valid_n;
            if_inst  <= inst_n;
            if_pc    <= ipc_n;
        end
    end

    assign pc_bad = ((pc >> (ADDR_BITS + 2)) != 32'd0) || (pc[1:0] != 2'b00);

`ifdef IFETCH_ZERO_HALT_EN
    assign zero_word = (rom_data == 32'h0000_0000);
`else
    assign zero_word = 1'b0;
`endif

    always_comb begin
        state_n = state;
        pc_n    = pc;
        valid_n = if_valid;
        inst_n  = if_inst;
        ipc_n   = if_pc;
        case (state)
            RUN: begin
                if (redirect_valid) begin
                    valid_n = 1'b0;
                    if (redirect_pc[1:0] != 2'b00) begin
                        state_n = FAULT;
                    end else begin
                        pc_n = redirect_pc;
                    end
                end else if (stall) begin
                    // everything holds
                end else if (pc_bad) begin
                    state_n = FAULT;
                    valid_n = 1'b0;
                end else if (zero_word) begin
                    state_n = HALT;
                    valid_n = 1'b0;
                end else begin
                    inst_n  = rom_data;
                    ipc_n   = pc;
                    valid_n = 1'b1;
                    pc_n    = pc + 32'd4;
                end
            end
            default: begin
                valid_n = 1'b0;
            end
        endcase
    end

    assign rom_addr = pc[ADDR_BITS+1:2];
    assign halted   = (state == HALT);
    assign fault    = (state == FAULT);

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed test-plan steps followed by
// randomized stall/redirect traffic compared against a behavioural model.
module tb_instr_fetch;

    localparam int AB = 5;
    localparam logic [31:0] ROM_BYTES = 32'd4 << AB;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          stall = 1'b0;
    logic          redirect_valid = 1'b0;
    logic [31:0]   redirect_pc = 32'h0;
    logic [AB-1:0] rom_addr;
    logic [31:0]   rom_data;
    logic          if_valid;
    logic [31:0]   if_inst;
    logic [31:0]   if_pc;
    logic          halted;
    logic          fault;

    logic [31:0] rom [0:31];
    assign rom_data = rom[rom_addr];

    always #5 clk = ~clk;

    instr_fetch #(.RESET_PC(32'h0), .ADDR_BITS(AB)) dut (
        .clk(clk), .reset(reset), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc),
        .halted(halted), .fault(fault)
    );

    int passed = 0;
    int total  = 0;

    // reference model: 0 = running, 1 = halted, 2 = faulted
    int          m_mode;
    logic [31:0] m_pc, m_inst, m_ipc;
    logic        m_valid;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %h, expected %h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_mode = 0; m_pc = 32'h0; m_inst = 32'h0; m_ipc = 32'h0; m_valid = 1'b0;
    endtask

    task automatic model_step();
        logic [31:0] w;
        if (m_mode != 0) begin
            m_valid = 1'b0;
        end else if (redirect_valid) begin
            m_valid = 1'b0;
            if (redirect_pc % 4 != 0) m_mode = 2;
            else m_pc = redirect_pc;
        end else if (stall) begin
        end else if (m_pc >= ROM_BYTES) begin
            m_mode = 2; m_valid = 1'b0;
        end else begin
            w = rom[m_pc / 4];
`ifdef IFETCH_ZERO_HALT_EN
            if (w == 32'h0) begin
                m_mode = 1; m_valid = 1'b0;
            end else begin
                m_inst = w; m_ipc = m_pc; m_valid = 1'b1; m_pc = m_pc + 4;
            end
`else
            m_inst = w; m_ipc = m_pc; m_valid = 1'b1; m_pc = m_pc + 4;
`endif
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".valid"},  {31'h0, if_valid}, {31'h0, m_valid});
        check({tag, ".inst"},   if_inst, m_inst);
        check({tag, ".pc"},     if_pc, m_ipc);
        check({tag, ".halted"}, {31'h0, halted}, {31'h0, m_mode == 1});
        check({tag, ".fault"},  {31'h0, fault}, {31'h0, m_mode == 2});
        check({tag, ".addr"},   {27'h0, rom_addr}, {27'h0, m_pc[AB+1:2]});
    endtask

    // one clock: model sees the inputs in place before the edge, outputs are sampled 1ns after
    task automatic cycle(input string tag);
        model_step();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic pulse_reset(input string tag);
        reset = 1'b1;
        #1;
        model_reset();
        check_all(tag);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        rom[0] = 32'h0030_0413; rom[1] = 32'h0010_0493;
        rom[2] = 32'h0100_0913; rom[3] = 32'h0094_62b3;
        for (int i = 4; i < 32; i++) rom[i] = $urandom | 32'h1;
        rom[5]  = 32'h0094_03b3;
        rom[13] = 32'h0122_8863;
        rom[30] = 32'h0000_0000;
        rom[31] = 32'h0000_0073;

        model_reset();
        #1;
        check_all("reset");
        #2;
        reset = 1'b0;

        cycle("e1"); check("e1.pc_const", if_pc, 32'h0); check("e1.inst_const", if_inst, 32'h0030_0413);
        cycle("e2"); check("e2.inst_const", if_inst, 32'h0010_0493);
        cycle("e3"); check("e3.inst_const", if_inst, 32'h0100_0913);
        cycle("e4"); check("e4.pc_const", if_pc, 32'hC); check("e4.inst_const", if_inst, 32'h0094_62b3);
        cycle("e5");

        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle("stall");
            check("stall.pc_const", if_pc, 32'h10);
            check("stall.addr_const", {27'h0, rom_addr}, 32'd5);
        end
        stall = 1'b0;
        cycle("release");
        check("release.pc_const", if_pc, 32'h14);
        check("release.inst_const", if_inst, 32'h0094_03b3);

        stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h34;
        cycle("redir");
        check("redir.bubble", {31'h0, if_valid}, 32'h0);
        stall = 1'b0; redirect_valid = 1'b0;
        cycle("redir_tgt");
        check("redir_tgt.pc_const", if_pc, 32'h34);
        check("redir_tgt.inst_const", if_inst, 32'h0122_8863);

        redirect_valid = 1'b1; redirect_pc = 32'h36;
        cycle("misalign");
        check("misalign.fault_const", {31'h0, fault}, 32'h1);
        redirect_pc = 32'h0;
        cycle("fault_sticky");
        check("fault_sticky.fault_const", {31'h0, fault}, 32'h1);
        redirect_valid = 1'b0;
        cycle("fault_hold");

        #2;
        pulse_reset("async_reset");
        for (int i = 0; i < 34; i++) begin
            cycle("seq");
            if (m_valid && m_ipc == 32'h78) check("zero_word_presented", if_inst, 32'h0);
        end
`ifdef IFETCH_ZERO_HALT_EN
        check("zh.halted", {31'h0, halted}, 32'h1);
        check("zh.valid", {31'h0, if_valid}, 32'h0);
        check("zh.addr", {27'h0, rom_addr}, 32'd30);
`else
        check("range.fault", {31'h0, fault}, 32'h1);
        check("range.valid", {31'h0, if_valid}, 32'h0);
        check("range.last_pc", if_pc, 32'h7C);
`endif

        #2;
        pulse_reset("rand_reset");
        for (int i = 0; i < 600; i++) begin
            stall = ($urandom_range(3) == 0);
            redirect_valid = ($urandom_range(6) == 0);
            case ($urandom_range(15))
                0:       redirect_pc = ($urandom_range(31) << 2) | $urandom_range(1, 3);
                1:       redirect_pc = ROM_BYTES + ($urandom_range(7) << 2);
                default: redirect_pc = $urandom_range(31) << 2;
            endcase
            cycle("rand");
            if (m_mode != 0 && $urandom_range(4) == 0) begin
                stall = 1'b0; redirect_valid = 1'b0;
                #2;
                pulse_reset("rand_reset");
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
